// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter that shares one memory port between instruction fetch and data access.
// Optional starvation guard for instruction fetch is enabled with `MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req_valid,
  input  logic [31:0] inst_req_addr,
  input  logic [3:0]  inst_req_do_read,
  input  logic [3:0]  inst_req_do_write,
  input  logic [31:0] inst_req_data,
  output logic        inst_rsp_valid,
  output logic [31:0] inst_rsp_addr,
  output logic [31:0] inst_rsp_data,
  output logic        inst_accept,

  input  logic        data_req_valid,
  input  logic [31:0] data_req_addr,
  input  logic [3:0]  data_req_do_read,
  input  logic [3:0]  data_req_do_write,
  input  logic [31:0] data_req_data,
  output logic        data_rsp_valid,
  output logic [31:0] data_rsp_addr,
  output logic [31:0] data_rsp_data,
  output logic        data_accept,

  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_do_read,
  output logic [3:0]  mem_req_do_write,
  output logic [31:0] mem_req_data,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_addr,
  input  logic [31:0] mem_rsp_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        force_inst;
  logic        data_win;

  assign data_win = data_req_valid && !(force_inst && inst_req_valid);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  logic [3:0] starve_q, starve_d;

  assign force_inst = (starve_q >= LIMIT);

  // Counts arbitrations that data won while fetch was waiting; any other IDLE outcome clears it.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (inst_req_valid && data_win) begin
        if (starve_q != 4'hF) begin
          starve_d = starve_q + 4'd1;
        end
      end else begin
        starve_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_limit;

  assign force_inst   = 1'b0;
  assign unused_limit = ^STARVE_LIMIT;
`endif

  // The request fields double as the registered memory request and are only nonzero during ISSUE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (inst_req_valid || data_req_valid) begin
          owner_d = data_win;
          valid_d = 1'b1;
          state_d = ISSUE;
          if (data_win) begin
            addr_d  = data_req_addr;
            rd_d    = data_req_do_read;
            wr_d    = data_req_do_write;
            wdata_d = data_req_data;
          end else begin
            addr_d  = inst_req_addr;
            rd_d    = inst_req_do_read;
            wr_d    = inst_req_do_write;
            wdata_d = inst_req_data;
          end
        end
      end
      ISSUE: begin
        valid_d = 1'b0;
        addr_d  = 32'd0;
        rd_d    = 4'd0;
        wr_d    = 4'd0;
        wdata_d = 32'd0;
        state_d = (rd_q != 4'd0) ? WAIT : IDLE;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= 32'd0;
      rd_q    <= 4'd0;
      wr_q    <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_req_valid    = valid_q;
  assign mem_req_addr     = addr_q;
  assign mem_req_do_read  = rd_q;
  assign mem_req_do_write = wr_q;
  assign mem_req_data     = wdata_q;

  assign inst_accept = (state_q == ISSUE) && !owner_q;
  assign data_accept = (state_q == ISSUE) && owner_q;

  // Responses are forwarded combinationally in the cycle memory returns them.
  assign inst_rsp_valid = (state_q == WAIT) && mem_rsp_valid && !owner_q;
  assign data_rsp_valid = (state_q == WAIT) && mem_rsp_valid && owner_q;
  assign inst_rsp_addr  = mem_rsp_addr;
  assign inst_rsp_data  = mem_rsp_data;
  assign data_rsp_addr  = mem_rsp_addr;
  assign data_rsp_data  = mem_rsp_data;

endmodule
